// File: rtl/tone_osc_if.sv
// rtl/tone_osc_if.sv - valid/ready sample stream from the oscillator to the audio transmitter
interface tone_osc_if #(parameter int SAMPLE_W = 24);
    logic                sample_valid;
    logic                sample_ready;
    logic [SAMPLE_W-1:0] sample_data;

    modport master (output sample_valid, output sample_data, input sample_ready);
    modport slave  (input sample_valid, input sample_data, output sample_ready);
endinterface

// File: rtl/tone_osc.sv
// rtl/tone_osc.sv - phase-accumulator square/saw/triangle oscillator with amplitude scaling
module tone_osc #(
    parameter int SAMPLE_W = 24,
    parameter int PHASE_W  = 24,
    parameter int AMP_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic               freq_load,
    input  logic [1:0]         wave_sel,
    input  logic [AMP_W-1:0]   amp,
    tone_osc_if.master         smp
);

    localparam int PROD_W = SAMPLE_W + AMP_W + 1;
    localparam logic [SAMPLE_W-1:0] MSB_ONLY = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0] SQ_POS   = {1'b0, {(SAMPLE_W-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, CALC, SCALE, HOLD} state_t;

    state_t              state;
    logic [PHASE_W-1:0]  phase;
    logic [PHASE_W-1:0]  freq_pend;
    logic [PHASE_W-1:0]  freq_act;
    logic [SAMPLE_W-1:0] raw;

    logic [SAMPLE_W-1:0] p;
    logic [SAMPLE_W-1:0] tri_t;
    logic [SAMPLE_W-1:0] raw_next;
    logic signed [PROD_W-1:0] raw_ext;
    logic signed [PROD_W-1:0] amp_ext;
    logic signed [PROD_W-1:0] prod;

    always_comb begin
        p     = phase[PHASE_W-1 -: SAMPLE_W];
        tri_t = {p[SAMPLE_W-2:0], 1'b0};
        if (p[SAMPLE_W-1]) begin
            tri_t = ~tri_t;
        end
        case (wave_sel)
            2'd0:    raw_next = p[SAMPLE_W-1] ? MSB_ONLY : SQ_POS;
            2'd1:    raw_next = p ^ MSB_ONLY;
            2'd2:    raw_next = tri_t ^ MSB_ONLY;
            default: raw_next = '0;
        endcase
    end

    // Full-width product of a signed sample and a zero-extended gain cannot overflow PROD_W.
    always_comb begin
        raw_ext = {{(AMP_W+1){raw[SAMPLE_W-1]}}, raw};
        amp_ext = {{(SAMPLE_W+1){1'b0}}, amp};
        prod    = raw_ext * amp_ext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            phase            <= '0;
            freq_pend        <= '0;
            freq_act         <= '0;
            raw              <= '0;
            smp.sample_valid <= 1'b0;
            smp.sample_data  <= '0;
        end else begin
            if (freq_load) begin
                freq_pend <= freq_word;
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    raw      <= raw_next;
                    freq_act <= freq_pend;
                    state    <= SCALE;
                end
                SCALE: begin
                    // Advance one cycle after CALC with the increment latched there; only
                    // CALC reads the phase, so this matches advancing inside CALC itself.
                    phase            <= phase + freq_act;
                    smp.sample_data  <= SAMPLE_W'(prod >>> AMP_W);
                    smp.sample_valid <= 1'b1;
                    state            <= HOLD;
                end
                HOLD: begin
                    if (smp.sample_ready) begin
                        smp.sample_valid <= 1'b0;
                        state            <= enable ? CALC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tone_osc.sv
// tb/tb_tone_osc.sv - vector table and scoreboard checks for tone_osc
module tb_tone_osc;
    localparam int SW = 24;
    localparam int PW = 24;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic [PW-1:0] freq_word = '0;
    logic          freq_load = 1'b0;
    logic [1:0]    wave_sel = '0;
    logic [AW-1:0] amp = '0;

    tone_osc_if #(.SAMPLE_W(SW)) sif();

    tone_osc #(.SAMPLE_W(SW), .PHASE_W(PW), .AMP_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .freq_word (freq_word),
        .freq_load (freq_load),
        .wave_sel  (wave_sel),
        .amp       (amp),
        .smp       (sif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    wave;
        logic [AW-1:0] gain;
        logic [SW-1:0] e0;
        logic [SW-1:0] e1;
        logic [SW-1:0] e2;
        logic [SW-1:0] e3;
    } vec_t;

    vec_t          vecs [7];
    int            n_tests = 0;
    int            n_fail = 0;
    int            cycle = 0;
    int            xfer_count = 0;
    int            xfer_cyc [$];
    logic [SW-1:0] sb [$];
    string         tag = "init";

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // A transfer happens on the posedge following a negedge that sees valid & ready.
    always @(negedge clk) begin
        if (rst && sif.sample_valid && sif.sample_ready) begin
            xfer_count++;
            xfer_cyc.push_back(cycle);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s_unexpected_xfer: got 0x%0h, expected no transfer", tag, sif.sample_data);
            end else begin
                check($sformatf("%s_sample%0d", tag, xfer_cyc.size()), 32'(sif.sample_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        check($sformatf("%s_sb_drained", tag), sb.size(), 0);
        sb.delete();
        rst = 1'b0;
        enable = 1'b0;
        sif.sample_ready = 1'b0;
        freq_load = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        xfer_cyc.delete();
    endtask

    task automatic load_freq(input logic [PW-1:0] f);
        freq_word = f;
        freq_load = 1'b1;
        tick();
        freq_load = 1'b0;
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int k = 0;
        while (xfer_count < target && k < budget) begin
            tick();
            k++;
        end
        check($sformatf("%s_xfer_count", tag), xfer_count, target);
    endtask

    task automatic wait_valid(input int budget, output int k);
        k = 0;
        while (!sif.sample_valid && k < budget) begin
            tick();
            k++;
        end
    endtask

    initial begin
        int base;
        int k;
        int bad;
        int n;

        vecs[0] = '{2'd0, 8'd128, 24'h3FFFFF, 24'h3FFFFF, 24'hC00000, 24'hC00000};
        vecs[1] = '{2'd1, 8'd128, 24'hC00000, 24'hE00000, 24'h000000, 24'h200000};
        vecs[2] = '{2'd2, 8'd128, 24'hC00000, 24'h000000, 24'h3FFFFF, 24'hFFFFFF};
        vecs[3] = '{2'd3, 8'd255, 24'h000000, 24'h000000, 24'h000000, 24'h000000};
        vecs[4] = '{2'd0, 8'd0,   24'h000000, 24'h000000, 24'h000000, 24'h000000};
        vecs[5] = '{2'd1, 8'd255, 24'h808000, 24'hC04000, 24'h000000, 24'h3FC000};
        vecs[6] = '{2'd0, 8'd1,   24'h007FFF, 24'h007FFF, 24'hFF8000, 24'hFF8000};

        sif.sample_ready = 1'b0;
        tick();
        tick();
        check("reset_valid", 32'(sif.sample_valid), 0);
        check("reset_data", 32'(sif.sample_data), 0);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            tag = $sformatf("vec%0d", i);
            do_reset();
            wave_sel = vecs[i].wave;
            amp = vecs[i].gain;
            load_freq(24'h400000);
            base = xfer_count;
            sb.push_back(vecs[i].e0);
            sb.push_back(vecs[i].e1);
            sb.push_back(vecs[i].e2);
            sb.push_back(vecs[i].e3);
            sif.sample_ready = 1'b1;
            enable = 1'b1;
            wait_xfers(base + 4, 40);
            enable = 1'b0;
            sif.sample_ready = 1'b0;
            n = xfer_cyc.size();
            if (n >= 4) check({tag, "_spacing"}, xfer_cyc[n-1] - xfer_cyc[n-4], 9);
            else check({tag, "_spacing_count"}, n, 4);
        end

        // Latency from enable, backpressure, and wave/amp changes during HOLD.
        tag = "bp";
        do_reset();
        wave_sel = 2'd1;
        amp = 8'd128;
        load_freq(24'h400000);
        enable = 1'b1;
        wait_valid(20, k);
        check("bp_enable_latency", k, 3);
        wave_sel = 2'd3;
        amp = 8'd0;
        bad = 0;
        repeat (20) begin
            tick();
            if (sif.sample_valid !== 1'b1 || sif.sample_data !== 24'hC00000) bad++;
        end
        check("bp_held_stable", bad, 0);
        wave_sel = 2'd1;
        amp = 8'd128;
        base = xfer_count;
        sb.push_back(24'hC00000);
        sif.sample_ready = 1'b1;
        tick();
        sif.sample_ready = 1'b0;
        check("bp_single_xfer", xfer_count, base + 1);
        check("bp_valid_drop", 32'(sif.sample_valid), 0);
        wait_valid(20, k);
        check("bp_next_latency", k + 1, 3);
        sb.push_back(24'hE00000);
        sif.sample_ready = 1'b1;
        tick();
        sif.sample_ready = 1'b0;
        enable = 1'b0;

        // Load coinciding with CALC: next sample still uses the old increment.
        tag = "fchg";
        do_reset();
        wave_sel = 2'd1;
        amp = 8'd128;
        load_freq(24'h400000);
        base = xfer_count;
        sb.push_back(24'hC00000);
        sb.push_back(24'hE00000);
        sb.push_back(24'h000000);
        sb.push_back(24'h080000);
        sif.sample_ready = 1'b1;
        enable = 1'b1;
        wait_xfers(base + 1, 20);
        freq_word = 24'h100000;
        freq_load = 1'b1;
        tick();
        freq_load = 1'b0;
        wait_xfers(base + 4, 40);
        enable = 1'b0;
        sif.sample_ready = 1'b0;

        // Phase 0xFFFFFF + 1 wraps to 0.
        tag = "wrap";
        do_reset();
        wave_sel = 2'd1;
        amp = 8'd128;
        load_freq(24'hFFFFFF);
        enable = 1'b1;
        wait_valid(20, k);
        load_freq(24'h000001);
        base = xfer_count;
        sb.push_back(24'hC00000);
        sb.push_back(24'h3FFFFF);
        sb.push_back(24'hC00000);
        sif.sample_ready = 1'b1;
        wait_xfers(base + 3, 40);
        enable = 1'b0;
        sif.sample_ready = 1'b0;

        // enable dropped during SCALE: sample still presented, then idle.
        tag = "endrop";
        do_reset();
        wave_sel = 2'd0;
        amp = 8'd128;
        load_freq(24'h400000);
        enable = 1'b1;
        tick();
        tick();
        enable = 1'b0;
        wait_valid(10, k);
        check("endrop_latency", k, 1);
        base = xfer_count;
        sb.push_back(24'h3FFFFF);
        sif.sample_ready = 1'b1;
        tick();
        check("endrop_xfer", xfer_count, base + 1);
        bad = 0;
        repeat (10) begin
            tick();
            if (sif.sample_valid !== 1'b0) bad++;
        end
        check("endrop_idle_no_valid", bad, 0);
        sif.sample_ready = 1'b0;

        // Asynchronous reset in HOLD, then restart from phase 0.
        tag = "rstmid";
        do_reset();
        wave_sel = 2'd1;
        amp = 8'd128;
        load_freq(24'h400000);
        enable = 1'b1;
        base = xfer_count;
        sb.push_back(24'hC00000);
        sif.sample_ready = 1'b1;
        wait_xfers(base + 1, 20);
        sif.sample_ready = 1'b0;
        wait_valid(20, k);
        check("rstmid_hold_reached", 32'(sif.sample_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        check("rstmid_valid", 32'(sif.sample_valid), 0);
        check("rstmid_data", 32'(sif.sample_data), 0);
        tick();
        rst = 1'b1;
        load_freq(24'h400000);
        base = xfer_count;
        sb.push_back(24'hC00000);
        sif.sample_ready = 1'b1;
        wait_xfers(base + 1, 20);
        enable = 1'b0;
        sif.sample_ready = 1'b0;
        tick();
        check("final_sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
